// File: rtl/regfile_dump_reader.sv
// Debug reader that walks every register through a read port and streams the words out over valid/ready.
// Build option: DUMP_CHECKSUM_EN appends one XOR checksum word after the last register.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   out_index
);

  // state | meaning
  // IDLE  | waiting for start
  // READ  | rd_addr = idx, capture rd_data at the edge
  // SEND  | word presented, waiting for handshake
  // DONE  | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              hs;
  logic              last;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] chk;
  logic              chk_phase;
`endif

  assign hs   = out_valid & out_ready;
  assign last = (idx == LAST_IDX);
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    rd_addr   = '0;
    case (state)
      IDLE: if (start) state_nxt = READ;
      READ: begin
        rd_addr   = idx;
        state_nxt = SEND;
      end
      SEND: begin
        rd_addr = idx;
        if (hs) begin
`ifdef DUMP_CHECKSUM_EN
          if (chk_phase)  state_nxt = DONE;
          else if (last)  state_nxt = SEND;
          else            state_nxt = READ;
`else
          state_nxt = last ? DONE : READ;
`endif
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
`ifdef DUMP_CHECKSUM_EN
      chk       <= '0;
      chk_phase <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx <= '0;
`ifdef DUMP_CHECKSUM_EN
            chk       <= '0;
            chk_phase <= 1'b0;
`endif
          end
        end
        READ: begin
          out_data  <= rd_data;
          out_index <= {1'b0, idx};
          out_valid <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
          chk <= chk ^ rd_data;
`endif
        end
        SEND: begin
          if (hs) begin
`ifdef DUMP_CHECKSUM_EN
            // After the last register the checksum word reuses SEND, so valid stays up
            if (chk_phase) begin
              out_valid <= 1'b0;
              chk_phase <= 1'b0;
            end else if (last) begin
              out_data  <= chk;
              out_index <= (ADDR_W+1)'(NUM_REGS);
              chk_phase <= 1'b1;
            end else begin
              idx       <= idx + ADDR_W'(1);
              out_valid <= 1'b0;
            end
`else
            if (!last) idx <= idx + ADDR_W'(1);
            out_valid <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: a queue of expected words built from the register
// array is compared against every handshake, plus directed timing, backpressure and reset cases.
module tb_regfile_dump_reader;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef DUMP_CHECKSUM_EN
  localparam int NW       = NR + 1;
  localparam int DONE_LAT = 65;
`else
  localparam int NW       = NR;
  localparam int DONE_LAT = 64;
`endif

  typedef struct {
    logic [AW:0]   idx;
    logic [DW-1:0] data;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, done, out_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, out_data;
  logic [AW:0]   out_index;

  logic [DW-1:0] regs [NR];
  assign rd_data = regs[rd_addr];

  regfile_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  word_t exp_q[$];
  int    words_seen, done_cnt, first_valid_cyc, done_cyc, last_hs_cyc, stall_seen;
  int    start_edge;
  logic [DW-1:0] first_data, data31, last_data;
  logic [AW:0]   last_index;

  // out_ready stimulus: 0 = always ready, 1 = random, 2 = hold off stall_idx for 5 cycles
  int ready_mode = 0;
  int stall_idx = -1;
  int stall_done = 0;
  always @(posedge clk) begin
    #1;
    if (ready_mode == 2) begin
      if (out_valid && int'(out_index) == stall_idx && stall_done < 5) begin
        out_ready = 1'b0;
        stall_done++;
      end else out_ready = 1'b1;
    end else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else begin
      out_ready = 1'b1;
      stall_done = 0;
    end
  end

  // Compare process
  logic  prev_stall = 1'b0;
  word_t prev_w;
  word_t mon_w;
  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(out_data), 64'(prev_w.data));
        check("hold_index", 64'(out_index), 64'(prev_w.idx));
      end
      if (out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        check("rd_addr_tracks", 64'(rd_addr),
              64'((int'(out_index) >= NR) ? NR - 1 : int'(out_index)));
        check("busy_with_valid", 64'(busy), 64'd1);
        if (out_ready) begin
          if (exp_q.size() == 0) check("unexpected_word", 64'(out_index), 64'hFFFF);
          else begin
            mon_w = exp_q.pop_front();
            check("word_index", 64'(out_index), 64'(mon_w.idx));
            check("word_data", 64'(out_data), 64'(mon_w.data));
          end
          words_seen++;
          if (words_seen == 1) first_data = out_data;
          if (int'(out_index) == NR - 1) data31 = out_data;
          last_data   = out_data;
          last_index  = out_index;
          last_hs_cyc = cyc;
        end else if (ready_mode == 2 && int'(out_index) == stall_idx) stall_seen++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_after_last", 64'(cyc), 64'(last_hs_cyc + 1));
        check("done_queue_empty", 64'(exp_q.size()), 64'd0);
        check("busy_in_done", 64'(busy), 64'd1);
        check("no_valid_in_done", 64'(out_valid), 64'd0);
      end
      prev_stall = out_valid && !out_ready;
      prev_w     = '{out_index, out_data};
    end
  end

  task automatic reset_stats();
    words_seen = 0; done_cnt = 0; first_valid_cyc = -1; done_cyc = -1;
    last_hs_cyc = -10; stall_seen = 0; data31 = '0;
    exp_q.delete();
  endtask

  // Expected stream: every register in order, then the XOR of all of them when checksummed
  task automatic load_expected();
    logic [DW-1:0] c;
    c = '0;
    for (int i = 0; i < NR; i++) begin
      exp_q.push_back('{(AW+1)'(i), regs[i]});
      c = c ^ regs[i];
    end
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back('{(AW+1)'(NR), c});
`endif
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    start_edge = cyc + 1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == 0) check("done_timeout", 64'd0, 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_dump(input int rmode, input int budget);
    reset_stats();
    load_expected();
    ready_mode = rmode;
    pulse_start();
    wait_done(budget);
  endtask

  task automatic wait_word(input int index, output logic found);
    found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge clk);
      if (out_valid && int'(out_index) == index) found = 1'b1;
    end
    if (!found) check("wait_word_timeout", 64'(index), 64'hFFFF);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    for (int i = 0; i < NR; i++) regs[i] = '0;
    reset_stats();

    // Reset held with start high
    rst = 1'b1; start = 1'b1;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_data", 64'(out_data), 64'd0);
      check("rst_rd_addr", 64'(rd_addr), 64'd0);
      check("rst_index", 64'(out_index), 64'd0);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle_after_rst", 64'(busy), 64'd0);

    // Full dump, always ready
    for (int i = 0; i < NR; i++) regs[i] = 32'hA500_0000 + 32'(i);
    run_dump(0, 200);
    check("dump_done_count", 64'(done_cnt), 64'd1);
    check("dump_words", 64'(words_seen), 64'(NW));
    check("first_valid_latency", 64'(first_valid_cyc - start_edge), 64'd1);
    check("done_latency", 64'(done_cyc - start_edge), 64'(DONE_LAT));
    check("first_word_lit", 64'(first_data), 64'hA500_0000);
    check("word31_lit", 64'(data31), 64'hA500_001F);
    check("idle_after_dump", 64'(busy), 64'd0);

    // Backpressure on word 3
    stall_idx = 3;
    run_dump(2, 300);
    check("stall_cycles", 64'(stall_seen), 64'd5);
    check("stall_words", 64'(words_seen), 64'(NW));
    check("stall_done_count", 64'(done_cnt), 64'd1);
    stall_idx = -1;

    // start pulsed mid-dump is ignored
    fork
      run_dump(0, 200);
      begin
        wait_word(10, found);
        if (found) pulse_start();
      end
    join
    repeat (5) @(negedge clk);
    check("ignored_start_words", 64'(words_seen), 64'(NW));
    check("ignored_start_dones", 64'(done_cnt), 64'd1);
    check("ignored_start_idle", 64'(busy), 64'd0);

    // Reset while word 17 is valid
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    reset_stats();
    load_expected();
    ready_mode = 1;
    pulse_start();
    wait_word(17, found);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); @(negedge clk);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_rd_addr", 64'(rd_addr), 64'd0);
    rst = 1'b0;
    run_dump(1, 600);
    check("redump_words", 64'(words_seen), 64'(NW));
    check("redump_dones", 64'(done_cnt), 64'd1);

    // Randomized contents and backpressure
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NR; i++) regs[i] = $urandom;
      run_dump(1, 600);
      check("rand_words", 64'(words_seen), 64'(NW));
      check("rand_dones", 64'(done_cnt), 64'd1);
    end

`ifdef DUMP_CHECKSUM_EN
    for (int i = 0; i < NR; i++) regs[i] = 32'(i);
    run_dump(0, 200);
    check("chk_last_index", 64'(last_index), 64'd32);
    check("chk_last_data", 64'(last_data), 64'h0);
    check("chk_words", 64'(words_seen), 64'd33);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Sequential debug reader that walks the 32-entry register file through one of its combinational read ports. It streams every register's contents out over a valid/ready interface for bench checking and on-board debug.
- Sits beside the datapath: drives the read-address input of a spare or muxed register-file read port and captures the corresponding read data.
- Pure reader. It never writes the register file.

Parameters:
- NUM_REGS, 32, number of registers walked, indices 0..NUM_REGS-1.
- ADDR_W, 5, register address width; NUM_REGS <= 2**ADDR_W.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a full dump; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse after the last word handshakes.
- rd_addr  output  ADDR_W  register index driven to the register-file read port.
- rd_data  input  DATA_W  combinational read data returned for rd_addr.
- out_valid  output  1  out_data/out_index hold a word.
- out_ready  input  1  consumer accepts the word when high together with out_valid.
- out_data  output  DATA_W  captured register value.
- out_index  output  ADDR_W+1  index of the word in out_data.

Behaviour:
- Reset values: busy=0, done=0, out_valid=0, out_data=0, out_index=0, rd_addr=0; state=IDLE; internal index=0.
- Reset takes priority over everything, including mid-dump. Next cycle is IDLE with reset values. A partially sent word is dropped.
- States: IDLE, READ, SEND, DONE.
- IDLE:
  - rd_addr=0.
  - If start=1 at the clock edge: idx<=0, go to READ. Otherwise stay.
- READ:
  - rd_addr=idx, combinational from the idx register.
  - At the edge: out_data<=rd_data, out_index<=idx (zero-extended), out_valid<=1, go to SEND.
- SEND:
  - out_valid=1; out_data and out_index are held stable until the handshake.
  - rd_addr keeps idx.
  - Handshake = out_valid & out_ready at the edge.
  - On handshake with idx==NUM_REGS-1: out_valid<=0, go to DONE.
  - On handshake otherwise: idx<=idx+1, out_valid<=0, go to READ.
  - Without handshake: stay, with no change to outputs.
- DONE:
  - done=1 for exactly this one cycle, then go to IDLE.
  - busy remains 1 in DONE.
- busy = (state != IDLE).
- start while busy: ignored, not queued.
- start held high continuously: a new dump begins in the cycle after DONE→IDLE is sampled with start=1.
- Throughput: with out_ready held high, each word takes 2 cycles (READ+SEND), so a 32-register dump takes 64 cycles plus 1 DONE cycle.
- Latency: start is accepted at edge N; the first out_valid is high in cycle N+2.
- Coherency: each word is the register value in its READ cycle. A write to that register in the same cycle is not visible, because register-file writes land at the clock edge. No whole-file snapshot is guaranteed.
- idx never exceeds NUM_REGS-1; there is no wrap-around.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined:
  - An accumulator chk (DATA_W) is cleared on start acceptance.
  - chk is XOR-ed with each captured register word.
  - After the last register handshakes, the FSM enters an extra SEND with out_data=chk and out_index=NUM_REGS. Its handshake leads to DONE.
  - Total words = NUM_REGS+1.
  - chk is reset to 0.
- Not defined: no accumulator and no extra word; exactly NUM_REGS words are sent.

Test Plan:
- Reset with rst=1 for 2 cycles, start=1 -> busy=0, out_valid=0, done=0, out_data=0, rd_addr=0. No dump starts while rst=1.
- Preload reg[i]=0xA5000000+i, start pulse, out_ready=1 -> 32 words, out_index 0..31, out_data 0xA5000000..0xA500001F.
  - First out_valid in cycle start+2; words 2 cycles apart.
  - done pulses once, 65 cycles after the start edge.
- Backpressure: out_ready low for 5 cycles while word 3 is valid -> out_data=0xA5000003 and out_index=3 held stable. rd_addr=3 throughout. Word 4 follows only after the handshake.
- start pulsed during word 10 -> ignored. Exactly 32 words total and a single done pulse.
- rst asserted while word 17 is valid -> next cycle IDLE, out_valid=0, busy=0. A new start re-dumps from index 0.
- DUMP_CHECKSUM_EN defined, reg[i]=i -> 33 words. The last word has out_index=32 and out_data=0x00000000 (XOR of 0..31). Then done.
